// File: rtl/stack_calc_sequencer_if.sv
// ============================================================================
// Module      : stack_calc_sequencer_if
// Description : Command handshake bundle between the key decoder (master)
//               and the RPN stack sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_calc_sequencer_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [WORD_WIDTH-1:0] cmd_data;
    logic                  done;
    logic                  error;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  done,
        input  error
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output done,
        output error
    );
endinterface

`default_nettype wire

// File: rtl/stack_calc_sequencer.sv
// ============================================================================
// Module      : stack_calc_sequencer
// Description : RPN sequencer driving a shift-register operand stack; issues
//               push/pop strobes, evaluates binary ops, tracks depth.
//               Optional multiplier enabled by macro STACK_CALC_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_calc_sequencer #(
    parameter int WORD_WIDTH = 8,
    parameter int STACK_SIZE = 4,
    parameter int DEPTH_W    = $clog2(STACK_SIZE + 1)
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    stack_calc_sequencer_if.slave      cmd,
    output logic                       stack_push,
    output logic                       stack_pop,
    output logic [WORD_WIDTH-1:0]      stack_write_data,
    input  wire logic [WORD_WIDTH-1:0] stack_read_data,
    output logic [DEPTH_W-1:0]         depth
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_POP1 = 2'd1;
    localparam logic [1:0] c_ST_POP2 = 2'd2;
    localparam logic [1:0] c_ST_PUSH = 2'd3;

    localparam logic [2:0] c_OP_PUSH = 3'd0;
    localparam logic [2:0] c_OP_DROP = 3'd1;
    localparam logic [2:0] c_OP_ADD  = 3'd2;
    localparam logic [2:0] c_OP_SUB  = 3'd3;
    localparam logic [2:0] c_OP_MUL  = 3'd4;
    localparam logic [2:0] c_OP_DUP  = 3'd5;

    localparam logic [DEPTH_W-1:0] c_DEPTH_FULL = DEPTH_W'(STACK_SIZE);
    localparam logic [DEPTH_W-1:0] c_DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] c_DEPTH_TWO  = DEPTH_W'(2);

    logic [1:0]            r_state;
    logic [DEPTH_W-1:0]    r_depth;
    logic [WORD_WIDTH-1:0] r_operand_a;
    logic [WORD_WIDTH-1:0] r_result;
    logic [2:0]            r_op;
    logic                  r_single_pop;
    logic                  r_done;
    logic                  r_error;

    logic                  w_full;
    logic                  w_has1;
    logic                  w_has2;
    logic [WORD_WIDTH-1:0] w_alu;

    assign w_full = (r_depth == c_DEPTH_FULL);
    assign w_has1 = (r_depth >= c_DEPTH_ONE);
    assign w_has2 = (r_depth >= c_DEPTH_TWO);

    // b is the entry below the original top (now top after the first pop), a the popped top.
    always_comb begin
        w_alu = '0;
        case (r_op)
            c_OP_ADD: w_alu = stack_read_data + r_operand_a;
            c_OP_SUB: w_alu = stack_read_data - r_operand_a;
`ifdef STACK_CALC_MUL_EN
            c_OP_MUL: w_alu = stack_read_data * r_operand_a;
`endif
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_depth      <= '0;
            r_operand_a  <= '0;
            r_result     <= '0;
            r_op         <= '0;
            r_single_pop <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        case (cmd.cmd_op)
                            c_OP_PUSH: begin
                                if (!w_full) begin
                                    r_result <= cmd.cmd_data;
                                    r_state  <= c_ST_PUSH;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            c_OP_DUP: begin
                                if (w_has1 && !w_full) begin
                                    r_result <= stack_read_data;
                                    r_state  <= c_ST_PUSH;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            c_OP_DROP: begin
                                if (w_has1) begin
                                    r_single_pop <= 1'b1;
                                    r_op         <= cmd.cmd_op;
                                    r_state      <= c_ST_POP1;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            c_OP_ADD, c_OP_SUB: begin
                                if (w_has2) begin
                                    r_single_pop <= 1'b0;
                                    r_op         <= cmd.cmd_op;
                                    r_state      <= c_ST_POP1;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                            c_OP_MUL: begin
`ifdef STACK_CALC_MUL_EN
                                if (w_has2) begin
                                    r_single_pop <= 1'b0;
                                    r_op         <= cmd.cmd_op;
                                    r_state      <= c_ST_POP1;
                                end else begin
                                    r_error <= 1'b1;
                                end
`else
                                r_error <= 1'b1;
`endif
                            end
                            default: r_error <= 1'b1;
                        endcase
                    end
                end
                c_ST_POP1: begin
                    r_operand_a <= stack_read_data;
                    r_depth     <= r_depth - c_DEPTH_ONE;
                    if (r_single_pop) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_POP2;
                    end
                end
                c_ST_POP2: begin
                    r_depth  <= r_depth - c_DEPTH_ONE;
                    r_result <= w_alu;
                    r_state  <= c_ST_PUSH;
                end
                c_ST_PUSH: begin
                    r_depth <= r_depth + c_DEPTH_ONE;
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign cmd.cmd_ready    = (r_state == c_ST_IDLE);
    assign cmd.done         = r_done;
    assign cmd.error        = r_error;
    assign stack_pop        = (r_state == c_ST_POP1) || (r_state == c_ST_POP2);
    assign stack_push       = (r_state == c_ST_PUSH);
    assign stack_write_data = r_result;
    assign depth            = r_depth;

endmodule

`default_nettype wire
